picorv32_mem_responder: RTL

Memory-side responder for the picorv32 native memory interface (mem_valid/mem_ready), used in formal and simulation benches in place of an unconstrained environment. It accepts one request at a time, answers after a configurable, stallable latency, and backs the address window with a small byte-writable RAM. It also flags out-of-window or misaligned accesses and initiator protocol violations with sticky error outputs.

---
 rtl/picorv32_mem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/picorv32_mem_responder.sv
// Memory-side responder for the picorv32 native mem_valid/mem_ready interface.
// Single outstanding request, stallable latency, byte-writable RAM, sticky error flags.
module picorv32_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic        stall,
  output logic        fault,
  output logic        proto_err,
  output logic [31:0] xfer_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [32:0]   WINDOW   = 33'd4 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            instr_q, instr_d;
  logic            in_range_q, in_range_d;
  logic            aligned_q, aligned_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            fault_q, fault_d;
  logic            proto_err_q, proto_err_d;
  logic [31:0]     xfer_count_q, xfer_count_d;

  logic [31:0]     ram [DEPTH];

  // In IDLE the live bus is decoded so that LATENCY == 0 can respond on the
  // acceptance edge; afterwards only the captured request is used.
  logic [31:0]           cur_addr;
  logic [3:0]            cur_wstrb;
  logic [31:0]           offset;
  logic                  cur_in_range;
  logic                  cur_aligned;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  enter_resp;

  assign cur_addr     = (state_q == IDLE) ? mem_addr  : addr_q;
  assign cur_wstrb    = (state_q == IDLE) ? mem_wstrb : wstrb_q;
  assign offset       = cur_addr - BASE_ADDR;
  assign cur_in_range = {1'b0, offset} < WINDOW;
  assign cur_aligned  = (cur_addr[1:0] == 2'b00);
  assign idx          = offset[DEPTH_LOG2+1:2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    instr_d      = instr_q;
    in_range_d   = in_range_q;
    aligned_d    = aligned_q;
    ready_d      = 1'b0;
    rdata_d      = '0;
    fault_d      = fault_q;
    proto_err_d  = proto_err_q;
    xfer_count_d = xfer_count_q;
    enter_resp   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          addr_d     = mem_addr;
          wdata_d    = mem_wdata;
          wstrb_d    = mem_wstrb;
          instr_d    = mem_instr;
          in_range_d = cur_in_range;
          aligned_d  = cur_aligned;
          if (LATENCY == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!stall) begin
          if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
          else             enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_d      = IDLE;
        xfer_count_d = xfer_count_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase

    if (enter_resp) begin
      state_d = RESP;
      ready_d = 1'b1;
      if (cur_in_range && cur_aligned) begin
        if (cur_wstrb == 4'b0000) rdata_d = ram[idx];
      end else begin
        fault_d = 1'b1;
      end
    end

    if (state_q != IDLE &&
        (!mem_valid || mem_addr != addr_q || mem_wdata != wdata_q ||
         mem_wstrb != wstrb_q || mem_instr != instr_q))
      proto_err_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      instr_q      <= 1'b0;
      in_range_q   <= 1'b0;
      aligned_q    <= 1'b0;
      ready_q      <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      proto_err_q  <= 1'b0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      instr_q      <= instr_d;
      in_range_q   <= in_range_d;
      aligned_q    <= aligned_d;
      ready_q      <= ready_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      proto_err_q  <= proto_err_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  // RAM is not reset; reset forces IDLE, so an in-flight write never commits.
  always_ff @(posedge clock) begin
    if (state_q == RESP && wstrb_q != 4'b0000 && in_range_q && aligned_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb_q[i]) ram[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_ready  = ready_q;
  assign mem_rdata  = rdata_q;
  assign fault      = fault_q;
  assign proto_err  = proto_err_q;
  assign xfer_count = xfer_count_q;

endmodule
